// File: rtl/time_counter.sv
// time_counter: 24-hour BCD real-time counter with set-mode load from the time-set FSM
module time_counter #(
    parameter int TICK_DIV = 100000000,
    parameter int PRE_W    = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       isset,
    input  logic [1:0] set_hour1,
    input  logic [3:0] set_hour2,
    input  logic [3:0] set_min1,
    input  logic [3:0] set_min2,
    input  logic [3:0] set_sec1,
    input  logic [3:0] set_sec2,
    output logic [1:0] hour1,
    output logic [3:0] hour2,
    output logic [3:0] min1,
    output logic [3:0] min2,
    output logic [3:0] sec1,
    output logic [3:0] sec2,
    output logic       sec_tick,
    output logic       day_wrap
);
    typedef enum logic {SET, RUN} state_t;
    state_t           state, state_nx;
    logic [PRE_W-1:0] pre, pre_cur, pre_nx;
    logic [1:0]       hour1_nx;
    logic [3:0]       hour2_nx, min1_nx, min2_nx, sec1_nx, sec2_nx;
    logic             tick, tick_nx, wrap_nx;
    logic             sec_ok, min_ok, hour_ok;
    logic             s2_c, s1_c, m2_c, m1_c, h_wrap;
    // prescaler restarts from zero on the first run edge after set mode
    assign pre_cur = (state == RUN) ? pre : '0;
    assign tick    = !isset && (pre_cur == PRE_W'(TICK_DIV - 1));
    assign sec_ok  = (set_sec1 <= 4'd5) && (set_sec2 <= 4'd9);
    assign min_ok  = (set_min1 <= 4'd5) && (set_min2 <= 4'd9);
    assign hour_ok = !((set_hour1 == 2'd3) || (set_hour2 > 4'd9) ||
                       (set_hour1 == 2'd2 && set_hour2 > 4'd3));
    assign s2_c    = sec2 == 4'd9;
    assign s1_c    = s2_c && sec1 == 4'd5;
    assign m2_c    = s1_c && min2 == 4'd9;
    assign m1_c    = m2_c && min1 == 4'd5;
    assign h_wrap  = m1_c && hour1 == 2'd2 && hour2 == 4'd3;
    // next-state, load validation and carry chain
    always_comb begin
        state_nx = isset ? SET : RUN;
        pre_nx   = '0;
        tick_nx  = 1'b0;
        wrap_nx  = 1'b0;
        hour1_nx = hour1;
        hour2_nx = hour2;
        min1_nx  = min1;
        min2_nx  = min2;
        sec1_nx  = sec1;
        sec2_nx  = sec2;
        if (isset) begin
            hour1_nx = hour_ok ? set_hour1 : 2'd0;
            hour2_nx = hour_ok ? set_hour2 : 4'd0;
            min1_nx  = min_ok ? set_min1 : 4'd0;
            min2_nx  = min_ok ? set_min2 : 4'd0;
            sec1_nx  = sec_ok ? set_sec1 : 4'd0;
            sec2_nx  = sec_ok ? set_sec2 : 4'd0;
        end else begin
            pre_nx  = tick ? '0 : pre_cur + PRE_W'(1);
            tick_nx = tick;
            if (tick) begin
                wrap_nx  = h_wrap;
                sec2_nx  = s2_c ? 4'd0 : sec2 + 4'd1;
                sec1_nx  = s1_c ? 4'd0 : (s2_c ? sec1 + 4'd1 : sec1);
                min2_nx  = m2_c ? 4'd0 : (s1_c ? min2 + 4'd1 : min2);
                min1_nx  = m1_c ? 4'd0 : (m2_c ? min1 + 4'd1 : min1);
                hour2_nx = !m1_c ? hour2 : (h_wrap || hour2 == 4'd9) ? 4'd0 : hour2 + 4'd1;
                hour1_nx = !m1_c ? hour1 : h_wrap ? 2'd0 : (hour2 == 4'd9) ? hour1 + 2'd1 : hour1;
            end
        end
    end
    // registered state, prescaler, digits and pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= SET;
            pre      <= '0;
            hour1    <= 2'd0;
            hour2    <= 4'd0;
            min1     <= 4'd0;
            min2     <= 4'd0;
            sec1     <= 4'd0;
            sec2     <= 4'd0;
            sec_tick <= 1'b0;
            day_wrap <= 1'b0;
        end else begin
            state    <= state_nx;
            pre      <= pre_nx;
            hour1    <= hour1_nx;
            hour2    <= hour2_nx;
            min1     <= min1_nx;
            min2     <= min2_nx;
            sec1     <= sec1_nx;
            sec2     <= sec2_nx;
            sec_tick <= tick_nx;
            day_wrap <= wrap_nx;
        end
    end
endmodule

// File: tb/tb_time_counter.sv
// tb_time_counter: directed self-checking bench for time_counter with TICK_DIV=4
module tb_time_counter;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       isset = 1'b1;
    logic [1:0] set_hour1 = 2'd0;
    logic [3:0] set_hour2 = 4'd0, set_min1 = 4'd0, set_min2 = 4'd0, set_sec1 = 4'd0, set_sec2 = 4'd0;
    logic [1:0] hour1;
    logic [3:0] hour2, min1, min2, sec1, sec2;
    logic       sec_tick, day_wrap;
    int         total = 0;
    int         bad = 0;

    time_counter #(.TICK_DIV(4), .PRE_W(3)) dut (
        .clk(clk), .reset(reset), .isset(isset),
        .set_hour1(set_hour1), .set_hour2(set_hour2), .set_min1(set_min1),
        .set_min2(set_min2), .set_sec1(set_sec1), .set_sec2(set_sec2),
        .hour1(hour1), .hour2(hour2), .min1(min1), .min2(min2), .sec1(sec1), .sec2(sec2),
        .sec_tick(sec_tick), .day_wrap(day_wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] t(input int h1, h2, m1, m2, s1, s2);
        return {2'(h1), 4'(h2), 4'(m1), 4'(m2), 4'(s1), 4'(s2)};
    endfunction

    function automatic logic [21:0] now();
        return {hour1, hour2, min1, min2, sec1, sec2};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input int h1, h2, m1, m2, s1, s2);
        set_hour1 = 2'(h1); set_hour2 = 4'(h2); set_min1 = 4'(m1);
        set_min2 = 4'(m2); set_sec1 = 4'(s1); set_sec2 = 4'(s2);
        isset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        load(1, 2, 3, 4, 5, 6);
        total++;
        if (now() !== t(0, 0, 0, 0, 0, 0) || sec_tick !== 1'b0 || day_wrap !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold got=%h tick=%b wrap=%b want=%h tick=0 wrap=0", now(), sec_tick, day_wrap, t(0,0,0,0,0,0));
        end
        reset = 1'b1;
        step();
        total++;
        if (now() !== t(1, 2, 3, 4, 5, 6) || sec_tick !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_load got=%h tick=%b want=%h tick=0", now(), sec_tick, t(1,2,3,4,5,6));
        end
    endtask

    task automatic test_run();
        load(1, 2, 3, 4, 5, 6);
        isset = 1'b0;
        for (int sec = 7; sec <= 8; sec++) begin
            for (int c = 1; c <= 3; c++) begin
                step();
                total++;
                if (sec_tick !== 1'b0 || now() !== t(1, 2, 3, 4, 5, sec - 1)) begin
                    bad++;
                    $display("FAIL run_idle c=%0d got=%h tick=%b want=%h tick=0", c, now(), sec_tick, t(1,2,3,4,5,sec-1));
                end
            end
            step();
            total++;
            if (sec_tick !== 1'b1 || now() !== t(1, 2, 3, 4, 5, sec)) begin
                bad++;
                $display("FAIL run_tick got=%h tick=%b want=%h tick=1", now(), sec_tick, t(1,2,3,4,5,sec));
            end
        end
    endtask

    task automatic test_day_wrap();
        load(2, 3, 5, 9, 5, 8);
        isset = 1'b0;
        repeat (4) step();
        total++;
        if (now() !== t(2, 3, 5, 9, 5, 9) || sec_tick !== 1'b1 || day_wrap !== 1'b0) begin
            bad++;
            $display("FAIL wrap_pre got=%h tick=%b wrap=%b want=%h tick=1 wrap=0", now(), sec_tick, day_wrap, t(2,3,5,9,5,9));
        end
        repeat (4) step();
        total++;
        if (now() !== t(0, 0, 0, 0, 0, 0) || sec_tick !== 1'b1 || day_wrap !== 1'b1) begin
            bad++;
            $display("FAIL wrap_edge got=%h tick=%b wrap=%b want=%h tick=1 wrap=1", now(), sec_tick, day_wrap, t(0,0,0,0,0,0));
        end
        step();
        total++;
        if (day_wrap !== 1'b0 || sec_tick !== 1'b0) begin
            bad++;
            $display("FAIL wrap_drop got tick=%b wrap=%b want tick=0 wrap=0", sec_tick, day_wrap);
        end
    endtask

    task automatic test_hour_carry();
        load(0, 9, 5, 9, 5, 9);
        isset = 1'b0;
        repeat (4) step();
        total++;
        if (now() !== t(1, 0, 0, 0, 0, 0) || day_wrap !== 1'b0) begin
            bad++;
            $display("FAIL carry_09 got=%h wrap=%b want=%h wrap=0", now(), day_wrap, t(1,0,0,0,0,0));
        end
        load(1, 9, 5, 9, 5, 9);
        isset = 1'b0;
        repeat (4) step();
        total++;
        if (now() !== t(2, 0, 0, 0, 0, 0) || day_wrap !== 1'b0) begin
            bad++;
            $display("FAIL carry_19 got=%h wrap=%b want=%h wrap=0", now(), day_wrap, t(2,0,0,0,0,0));
        end
    endtask

    task automatic test_validation();
        load(3, 1, 7, 0, 4, 5);
        total++;
        if (now() !== t(0, 0, 0, 0, 4, 5)) begin
            bad++;
            $display("FAIL valid_h3_m70 got=%h want=%h", now(), t(0,0,0,0,4,5));
        end
        load(2, 5, 3, 4, 5, 6);
        total++;
        if (now() !== t(0, 0, 3, 4, 5, 6)) begin
            bad++;
            $display("FAIL valid_h25 got=%h want=%h", now(), t(0,0,3,4,5,6));
        end
        load(2, 3, 5, 9, 6, 0);
        total++;
        if (now() !== t(2, 3, 5, 9, 0, 0)) begin
            bad++;
            $display("FAIL valid_s60 got=%h want=%h", now(), t(2,3,5,9,0,0));
        end
        load(1, 10, 5, 12, 5, 9);
        total++;
        if (now() !== t(0, 0, 0, 0, 5, 9)) begin
            bad++;
            $display("FAIL valid_units got=%h want=%h", now(), t(0,0,0,0,5,9));
        end
    endtask

    task automatic test_back_to_back();
        load(1, 2, 0, 0, 0, 0);
        isset = 1'b0;
        repeat (3) step();
        isset = 1'b1;
        step();
        total++;
        if (sec_tick !== 1'b0 || now() !== t(1, 2, 0, 0, 0, 0)) begin
            bad++;
            $display("FAIL set_priority got=%h tick=%b want=%h tick=0", now(), sec_tick, t(1,2,0,0,0,0));
        end
        isset = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            step();
            total++;
            if (sec_tick !== 1'b0) begin
                bad++;
                $display("FAIL restart_idle c=%0d got tick=%b want tick=0", c, sec_tick);
            end
        end
        step();
        total++;
        if (sec_tick !== 1'b1 || now() !== t(1, 2, 0, 0, 0, 1)) begin
            bad++;
            $display("FAIL restart_tick got=%h tick=%b want=%h tick=1", now(), sec_tick, t(1,2,0,0,0,1));
        end
        reset = 1'b0;
        #1;
        total++;
        if (now() !== t(0, 0, 0, 0, 0, 0) || sec_tick !== 1'b0 || day_wrap !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got=%h tick=%b wrap=%b want=%h tick=0 wrap=0", now(), sec_tick, day_wrap, t(0,0,0,0,0,0));
        end
        reset = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_run();
        test_day_wrap();
        test_hour_carry();
        test_validation();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/time_counter.md
Name: time_counter

Overview:
- Running-time stage directly downstream of the time-set FSM.
- While `isset` is high it continuously loads the six BCD digits produced by the set FSM. When `isset` is low it counts real time in 24-hour format, 00:00:00 to 23:59:59, from an internal prescaler.
- Its digit outputs feed the display driver.

Parameters:
- TICK_DIV, default 100000000: clk cycles per second. Legal range is at least 2; benches use 4.
- PRE_W, default 27: prescaler width. Must satisfy 2^PRE_W >= TICK_DIV.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
- isset  input  1  level; 1 = set mode (load and hold), 0 = run mode.
- set_hour1  input  2  hours tens digit from the set FSM.
- set_hour2  input  4  hours units digit.
- set_min1  input  4  minutes tens digit.
- set_min2  input  4  minutes units digit.
- set_sec1  input  4  seconds tens digit.
- set_sec2  input  4  seconds units digit.
- hour1  output  2  hours tens digit, BCD.
- hour2  output  4  hours units digit, BCD.
- min1  output  4  minutes tens digit, BCD.
- min2  output  4  minutes units digit, BCD.
- sec1  output  4  seconds tens digit, BCD.
- sec2  output  4  seconds units digit, BCD.
- sec_tick  output  1  one-cycle pulse in the cycle the seconds value advances.
- day_wrap  output  1  one-cycle pulse in the cycle the time wraps 23:59:59 to 00:00:00.

Behaviour:
- Reset (reset=0, asynchronous):
  - all digits = 0
  - prescaler = 0
  - state = SET
  - sec_tick = 0, day_wrap = 0
  - Release is synchronous in effect: the first active edge is the first edge with reset=1.
- States:
  - SET: taken whenever `isset`=1 at an edge.
  - RUN: taken whenever `isset`=0 at an edge.
  - No other states. The encoding is implementer's choice.
- SET state, each edge with isset=1:
  - Digits load from the set_* inputs after validation.
  - Prescaler is cleared to 0.
  - sec_tick = 0, day_wrap = 0.
  - Latency: outputs show the loaded value one cycle after isset is sampled high. Set-input changes made while isset stays high track with one-cycle latency.
- Load validation, applied per field:
  - Seconds: if set_sec1>5 or set_sec2>9, both seconds digits load 0.
  - Minutes: the same rule applies to the minutes pair.
  - Hours: if set_hour1=3, or set_hour2>9, or (set_hour1=2 and set_hour2>3), both hour digits load 0.
  - Valid fields load unchanged.
- RUN state, each edge with isset=0:
  - Prescaler increments.
  - When prescaler = TICK_DIV-1: it returns to 0, time advances by one second, and sec_tick=1 for that cycle. Otherwise sec_tick=0.
  - The first advance after leaving SET occurs exactly TICK_DIV cycles after the first edge sampled with isset=0.
- Carry chain, all evaluated in the same cycle:
  - sec2 9→0 carries into sec1.
  - sec1 5→0 carries into min2.
  - min2 9→0 carries into min1.
  - min1 5→0 carries into the hours.
  - hour2 9→0 with hour1+1.
  - Hours 23 → 00 when minutes and seconds carry; day_wrap=1 in that same cycle.
- Digit ranges: digits never leave their legal ranges.
  - hour1 0..2
  - hour2 0..9, and 0..3 when hour1=2
  - min1 and sec1 0..5
  - min2 and sec2 0..9
- isset rising mid-second: the partial prescaler count is discarded and no tick is issued in that cycle. SET takes priority over a coincident terminal count.
- isset falling: counting restarts from prescaler 0. No pulse is generated on the transition.
- Reset asserted mid-count or mid-set: immediate return to 00:00:00 in SET. Pulses drop to 0.
- Outputs are registered. sec_tick and day_wrap never stay high two consecutive cycles when TICK_DIV>=2.

Test Plan (TICK_DIV=4):
- Reset low, then high with isset=1 and set inputs 1,2,3,4,5,6 → outputs 00:00:00 during reset; 12:34:56 one cycle after the first active edge; sec_tick=0 throughout.
- Load 12:34:56, drop isset → first sec_tick and 12:34:57 exactly 4 cycles later; 12:34:58 after 8 cycles; period is 4 cycles.
- Load 23:59:58, run 8 cycles → 23:59:59, then 00:00:00 with sec_tick=1 and day_wrap=1 in the same cycle; day_wrap is low on the next cycle.
- Load 09:59:59, run 4 cycles → 10:00:00 (hour carry 09→10, no day_wrap); load 19:59:59 → 20:00:00.
- Load invalid hour1=3/hour2=1 with minutes 7:0 and seconds 4:5 → outputs 00:00:45 (hours and minutes zeroed, seconds kept); load hour1=2/hour2=5 → hours 00.
- Run for 3 cycles, raise isset for 1 cycle with the same values, drop it → no tick in the raised cycle; next tick 4 cycles after the drop. Assert reset mid-run → immediate 00:00:00, pulses 0.
